sdram_write: RTL and testbench

Write-side SDRAM engine: accepts a write request (start address and length in 4-word bursts), requests the command bus from the SDRAM arbiter, then issues ACTIVE / WRITE / PRECHARGE. Write data is pulled from an upstream FIFO one word per cycle and driven onto the SDRAM DQ bus. It sits beside the read engine under the same arbiter, uses the same command encoding, and targets a single bank.

---
 rtl/sdram_write.sv | 203 ++++++++++++++++++++
 tb/tb_sdram_write.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_write.sv
// Write-side SDRAM engine: arbiter handshake, then ACTIVE / WRITE bursts / PRECHARGE on one bank.
// Write data streams from an upstream FIFO straight onto the DQ bus.
module sdram_write (
  input  logic        sclk,
  input  logic        srst_n,
  input  logic        wr_trig,
  input  logic [7:0]  wr_len,
  input  logic [20:0] wr_addr,
  input  logic        wr_en,
  output logic        flag_wr_ask,
  output logic        flag_wr_end,
  output logic        wr_data_req,
  input  logic [15:0] wr_data,
  output logic [3:0]  sdram_cmd,
  output logic [11:0] sdram_addr,
  output logic [1:0]  sdram_bank,
  output logic [15:0] sdram_dq,
  output logic        sdram_dq_oe
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASK,
    S_ACT,
    S_WR,
    S_PRE
  } state_t;

  state_t      r_state, w_nxt_state;
  logic [1:0]  r_cnt, w_nxt_cnt;
  logic [11:0] r_row;
  logic [8:0]  r_col;
  logic [7:0]  r_rem;
  logic        r_wrap;
  logic        r_cont;
  logic        r_go_act;

  logic        w_cont;
  logic        w_go_act;
  logic [9:0]  w_col_inc;

  logic [3:0]  r_cmd, w_cmd;
  logic [11:0] r_addr, w_addr;
  logic        r_oe, w_oe;
  logic        r_req, w_req;
  logic        r_end, w_end;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_cont      = (r_rem != 8'd0) && wr_en && !r_wrap;
    w_go_act    = (r_rem != 8'd0) && wr_en;
    w_col_inc   = {1'b0, r_col} + 10'd4;

    case (r_state)
      S_IDLE: begin
        if (wr_trig && (wr_len != 8'd0)) begin
          w_nxt_state = S_ASK;
          w_nxt_cnt   = 2'd0;
        end
      end
      S_ASK: begin
        if (wr_en) begin
          w_nxt_state = S_ACT;
          w_nxt_cnt   = 2'd0;
        end
      end
      S_ACT: begin
        if (r_cnt == 2'd1) begin
          w_nxt_state = S_WR;
          w_nxt_cnt   = 2'd0;
        end else begin
          w_nxt_cnt = r_cnt + 2'd1;
        end
      end
      S_WR: begin
        if (r_cnt == 2'd3) begin
          w_nxt_state = r_cont ? S_WR : S_PRE;
          w_nxt_cnt   = 2'd0;
        end else begin
          w_nxt_cnt = r_cnt + 2'd1;
        end
      end
      S_PRE: begin
        if (r_cnt == 2'd2) begin
          w_nxt_cnt = 2'd0;
          if (r_go_act)
            w_nxt_state = S_ACT;
          else if (r_rem == 8'd0)
            w_nxt_state = S_IDLE;
          else
            w_nxt_state = S_ASK;
        end else begin
          w_nxt_cnt = r_cnt + 2'd1;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_cnt   = 2'd0;
      end
    endcase
  end

  // Bus outputs are registered from the next state so each command lands in its own slot.
  always_comb begin
    w_cmd  = CMD_NOP;
    w_addr = '0;
    w_oe   = 1'b0;
    w_req  = 1'b0;
    w_end  = 1'b0;
    case (w_nxt_state)
      S_ACT: begin
        if (w_nxt_cnt == 2'd0) begin
          w_cmd  = CMD_ACT;
          w_addr = r_row;
        end else begin
          w_req = 1'b1;
        end
      end
      S_WR: begin
        w_oe  = 1'b1;
        w_req = (w_nxt_cnt != 2'd3) || w_cont;
        if (w_nxt_cnt == 2'd0) begin
          w_cmd  = CMD_WR;
          w_addr = {3'b000, r_col};
        end
      end
      S_PRE: begin
        if (w_nxt_cnt == 2'd1) begin
          w_cmd  = CMD_PRE;
          w_addr = 12'h400;
        end
        if (w_nxt_cnt == 2'd2)
          w_end = !w_go_act;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 2'd0;
      r_row    <= '0;
      r_col    <= '0;
      r_rem    <= '0;
      r_wrap   <= 1'b0;
      r_cont   <= 1'b0;
      r_go_act <= 1'b0;
      r_cmd    <= CMD_NOP;
      r_addr   <= '0;
      r_oe     <= 1'b0;
      r_req    <= 1'b0;
      r_end    <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_cmd   <= w_cmd;
      r_addr  <= w_addr;
      r_oe    <= w_oe;
      r_req   <= w_req;
      r_end   <= w_end;

      if ((r_state == S_IDLE) && wr_trig && (wr_len != 8'd0)) begin
        r_row <= wr_addr[20:9];
        r_col <= wr_addr[8:0];
        r_rem <= wr_len;
      end

      if (r_state == S_WR) begin
        case (r_cnt)
          2'd0: r_rem <= r_rem - 8'd1;
          2'd1: begin
            r_col  <= w_col_inc[8:0];
            r_wrap <= w_col_inc[9];
            if (w_col_inc[9])
              r_row <= r_row + 12'd1;
          end
          2'd2: r_cont <= w_cont;
          default: ;
        endcase
      end

      if ((r_state == S_PRE) && (r_cnt == 2'd1))
        r_go_act <= w_go_act;
    end
  end

  assign sdram_cmd   = r_cmd;
  assign sdram_addr  = r_addr;
  assign sdram_bank  = 2'b00;
  assign sdram_dq_oe = r_oe;
  assign sdram_dq    = r_oe ? wr_data : '0;
  assign wr_data_req = r_req;
  assign flag_wr_end = r_end;
  assign flag_wr_ask = (r_state == S_ASK);

endmodule

// File: tb/tb_sdram_write.sv
// Cycle-accurate bench for sdram_write: per-cycle {inputs, expected outputs} records built from
// the command timeline, applied in order and compared; a FIFO model answers wr_data_req.
module tb_sdram_write;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] WRC = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010;

  logic        sclk = 1'b0;
  logic        srst_n = 1'b0;
  logic        wr_trig = 1'b0;
  logic [7:0]  wr_len = '0;
  logic [20:0] wr_addr = '0;
  logic        wr_en = 1'b0;
  logic        flag_wr_ask, flag_wr_end, wr_data_req;
  logic [15:0] wr_data = 16'h5555;
  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_bank;
  logic [15:0] sdram_dq;
  logic        sdram_dq_oe;

  sdram_write dut (
    .sclk        (sclk),
    .srst_n      (srst_n),
    .wr_trig     (wr_trig),
    .wr_len      (wr_len),
    .wr_addr     (wr_addr),
    .wr_en       (wr_en),
    .flag_wr_ask (flag_wr_ask),
    .flag_wr_end (flag_wr_end),
    .wr_data_req (wr_data_req),
    .wr_data     (wr_data),
    .sdram_cmd   (sdram_cmd),
    .sdram_addr  (sdram_addr),
    .sdram_bank  (sdram_bank),
    .sdram_dq    (sdram_dq),
    .sdram_dq_oe (sdram_dq_oe)
  );

  always #5 sclk = ~sclk;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [11:0] addr;
    logic [1:0]  bank;
    logic        oe;
    logic        req;
    logic        ask;
    logic        fend;
    logic [15:0] dq;
  } out_t;

  typedef struct {
    bit          rst;
    bit          trig;
    logic [7:0]  len;
    logic [20:0] addr;
    bit          en;
    out_t        exp;
  } vec_t;

  vec_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          fifo_n = 0;
  bit          req_q = 1'b0;

  bit          g_rst = 1'b0;
  bit          g_trig = 1'b0;
  logic [7:0]  g_len = '0;
  logic [20:0] g_addr = '0;
  bit          g_en = 1'b0;
  int          g_beat = 0;

  task automatic push(input logic [3:0] cmd, input logic [11:0] a,
                      input bit oe, input bit req, input bit ask, input bit fend);
    vec_t v;
    v.rst  = g_rst;
    v.trig = g_trig;
    v.len  = g_len;
    v.addr = g_addr;
    v.en   = g_en;
    v.exp  = '{cmd: cmd, addr: a, bank: 2'b00, oe: oe, req: req, ask: ask, fend: fend,
               dq: oe ? (16'hA000 + 16'(g_beat)) : 16'h0000};
    if (oe) g_beat++;
    q.push_back(v);
    g_trig = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) push(NOP, 12'h0, 0, 0, 0, 0);
  endtask

  task automatic reset_cycles(input int n);
    g_rst = 1'b1;
    repeat (n) push(NOP, 12'h0, 0, 0, 0, 0);
    g_rst = 1'b0;
  endtask

  task automatic trig(input logic [20:0] a, input logic [7:0] len);
    g_trig = 1'b1;
    g_addr = a;
    g_len  = len;
    push(NOP, 12'h0, 0, 0, 0, 0);
  endtask

  task automatic ask(input int n);
    repeat (n) push(NOP, 12'h0, 0, 0, 1, 0);
  endtask

  task automatic act(input logic [11:0] row);
    push(ACT, row, 0, 0, 0, 0);
    push(NOP, 12'h0, 0, 1, 0, 0);
  endtask

  task automatic burst(input logic [8:0] col, input bit cont, input bit drop);
    push(WRC, {3'b000, col}, 1, 1, 0, 0);
    if (drop) g_en = 1'b0;
    push(NOP, 12'h0, 1, 1, 0, 0);
    push(NOP, 12'h0, 1, 1, 0, 0);
    push(NOP, 12'h0, 1, cont, 0, 0);
  endtask

  task automatic pre(input bit fend);
    push(NOP, 12'h0, 0, 0, 0, 0);
    push(PRE, 12'h400, 0, 0, 0, 0);
    push(NOP, 12'h0, 0, 0, 0, fend);
  endtask

  task automatic run(input string name);
    vec_t v;
    out_t got;
    int   n = 0;
    fifo_n = 0;
    while (q.size() > 0) begin
      v = q.pop_front();
      @(posedge sclk);
      #1;
      srst_n  = !v.rst;
      wr_trig = v.trig;
      wr_len  = v.len;
      wr_addr = v.addr;
      wr_en   = v.en;
      if (req_q) begin
        wr_data = 16'hA000 + 16'(fifo_n);
        fifo_n++;
      end
      @(negedge sclk);
      got = '{cmd: sdram_cmd, addr: sdram_addr, bank: sdram_bank, oe: sdram_dq_oe,
              req: wr_data_req, ask: flag_wr_ask, fend: flag_wr_end, dq: sdram_dq};
      checks++;
      if (got !== v.exp) begin
        errors++;
        $display("FAIL %s cyc%0d: got cmd=%b addr=%h bank=%0d oe=%b req=%b ask=%b end=%b dq=%h, exp cmd=%b addr=%h bank=%0d oe=%b req=%b ask=%b end=%b dq=%h",
                 name, n, got.cmd, got.addr, got.bank, got.oe, got.req, got.ask, got.fend, got.dq,
                 v.exp.cmd, v.exp.addr, v.exp.bank, v.exp.oe, v.exp.req, v.exp.ask, v.exp.fend, v.exp.dq);
      end
      req_q = wr_data_req;
      n++;
    end
  endtask

  task automatic start_test();
    q.delete();
    g_beat = 0;
    g_en   = 1'b1;
  endtask

  initial begin
    // Power-on reset and idle bus
    start_test();
    g_en = 1'b0;
    reset_cycles(2);
    idle(3);
    run("reset");

    // Single burst: row 5, col 16
    start_test();
    trig(21'h00A10, 8'd1);
    ask(1);
    act(12'd5);
    burst(9'd16, 0, 0);
    pre(1);
    idle(3);
    run("single");

    // Three back-to-back bursts from col 0 of row 2
    start_test();
    trig(21'h00400, 8'd3);
    ask(1);
    act(12'd2);
    burst(9'd0, 1, 0);
    burst(9'd4, 1, 0);
    burst(9'd8, 0, 0);
    pre(1);
    idle(3);
    run("multi");

    // Column wrap 508 -> 0 moves to row 8 without releasing the bus
    start_test();
    trig(21'h00FFC, 8'd2);
    ask(1);
    act(12'd7);
    burst(9'd508, 0, 0);
    pre(0);
    act(12'd8);
    burst(9'd0, 0, 0);
    pre(1);
    idle(3);
    run("rowcross");

    // Grant dropped during first burst's d1: release, re-ask, resume at col+4 with 3 bursts
    start_test();
    trig(21'h00614, 8'd4);
    ask(1);
    act(12'd3);
    burst(9'd20, 0, 1);
    pre(1);
    ask(3);
    g_en = 1'b1;
    ask(1);
    act(12'd3);
    burst(9'd24, 1, 0);
    burst(9'd28, 1, 0);
    burst(9'd32, 0, 0);
    pre(1);
    idle(3);
    run("grantloss");

    // Zero-length request is a no-op
    start_test();
    trig(21'h00A10, 8'd0);
    idle(5);
    run("len0");

    // Stray trigger while writing must not alter the transfer
    start_test();
    trig(21'h01228, 8'd1);
    ask(1);
    act(12'd9);
    g_trig = 1'b1;
    g_len  = 8'd5;
    g_addr = 21'h1FFFFC;
    burst(9'd40, 0, 0);
    pre(1);
    idle(4);
    run("trig_in_wr");

    // Asynchronous reset at beat d2 aborts at once, no PRE afterwards
    start_test();
    trig(21'h00A10, 8'd1);
    ask(1);
    act(12'd5);
    push(WRC, 12'h010, 1, 1, 0, 0);
    push(NOP, 12'h0, 1, 1, 0, 0);
    reset_cycles(2);
    idle(8);
    run("async_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
